// File: rtl/arbitro_jogadores_pkg.sv
// Shared definitions for the quiz-game answer arbiter: state encodings,
// default sizing and a small width helper.
package arbitro_jogadores_pkg;

  localparam int unsigned N_JOG_PADRAO   = 4;
  localparam int unsigned W_BOT_PADRAO   = 4;
  localparam int unsigned TIMEOUT_PADRAO = 5000;
  localparam int unsigned W_ESTADO       = 3;

  typedef enum logic [W_ESTADO-1:0] {
    OCIOSO    = 3'd0,
    ARMADO    = 3'd1,
    CONCEDIDO = 3'd2,
    ESGOTADO  = 3'd3
  } estado_t;

  // Player index width; a single player still needs one bit.
  function automatic int unsigned largura_idx(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_jogadores_if.sv
// Controller/button side bundle of the answer arbiter.
interface arbitro_jogadores_if
  import arbitro_jogadores_pkg::*;
#(
  parameter int unsigned N_JOG   = N_JOG_PADRAO,
  parameter int unsigned W_BOT   = W_BOT_PADRAO,
  parameter int unsigned TIMEOUT = TIMEOUT_PADRAO
);

  localparam int unsigned W_IDX   = largura_idx(N_JOG);
  localparam int unsigned W_TEMPO = $clog2(TIMEOUT + 1);

  logic                     habilita;
  logic                     limpa;
  logic                     ack;
  logic [N_JOG*W_BOT-1:0]   botoes;
  logic                     jogada_feita;
  logic [W_IDX-1:0]         jogador;
  logic [W_BOT-1:0]         botao_sel;
  logic                     tempo_esgotado;
  logic [W_TEMPO-1:0]       tempo_restante;
  logic [W_ESTADO-1:0]      db_estado;

  // Controller and buttons drive the requests.
  modport master (
    output habilita, limpa, ack, botoes,
    input  jogada_feita, jogador, botao_sel, tempo_esgotado, tempo_restante, db_estado
  );

  // The arbiter consumes requests and reports results.
  modport slave (
    input  habilita, limpa, ack, botoes,
    output jogada_feita, jogador, botao_sel, tempo_esgotado, tempo_restante, db_estado
  );

endinterface

// File: rtl/arbitro_jogadores_rr.sv
// Combinational round-robin selector: first candidate at or after ptr,
// wrapping around the player count.
module arbitro_rr #(
  parameter int unsigned N_JOG = 4,
  parameter int unsigned W_IDX = 2
) (
  input  logic [N_JOG-1:0] candidatos,
  input  logic [W_IDX-1:0] ptr,
  output logic             valido,
  output logic [W_IDX-1:0] vencedor
);

  logic [W_IDX:0] idx;

  // Walk the players starting at ptr; the first hit wins.
  always_comb begin
    valido   = 1'b0;
    vencedor = '0;
    idx      = '0;
    for (int i = 0; i < int'(N_JOG); i++) begin
      idx = (W_IDX+1)'(ptr) + (W_IDX+1)'(i);
      if (idx >= (W_IDX+1)'(N_JOG)) begin
        idx = idx - (W_IDX+1)'(N_JOG);
      end
      for (int j = 0; j < int'(N_JOG); j++) begin
        if (!valido && candidatos[j] && (idx == (W_IDX+1)'(j))) begin
          valido   = 1'b1;
          vencedor = W_IDX'(j);
        end
      end
    end
  end

endmodule

// File: rtl/arbitro_jogadores.sv
// Multi-player answer arbiter: once armed, grants the first fresh press
// (round-robin on ties), holds it until ack, or reports a timeout.
module arbitro_jogadores
  import arbitro_jogadores_pkg::*;
#(
  parameter int unsigned N_JOG   = N_JOG_PADRAO,
  parameter int unsigned W_BOT   = W_BOT_PADRAO,
  parameter int unsigned TIMEOUT = TIMEOUT_PADRAO
) (
  input logic           clock,
  input logic           reset,
  arbitro_jogadores_if.slave bus
);

  localparam int unsigned W_IDX   = largura_idx(N_JOG);
  localparam int unsigned W_TEMPO = $clog2(TIMEOUT + 1);

  estado_t              estado, estado_nxt;
  logic [N_JOG-1:0]     ativo, ativo_ant, candidatos;
  logic [N_JOG-1:0]     mascara, mascara_nxt;
  logic [W_IDX-1:0]     ptr, ptr_nxt;
  logic [W_IDX-1:0]     vencedor;
  logic                 valido;
  logic [W_BOT-1:0]     botao_vencedor;
  logic [W_IDX-1:0]     jogador_q, jogador_nxt;
  logic [W_BOT-1:0]     botao_q, botao_nxt;
  logic [W_TEMPO-1:0]   timer, timer_nxt;
  logic                 jf_q, jf_nxt;
  logic                 te_q, te_nxt;

  // A player is active while any of its buttons is held.
  always_comb begin
    ativo = '0;
    for (int p = 0; p < int'(N_JOG); p++) begin
      ativo[p] = |bus.botoes[p*W_BOT +: W_BOT];
    end
  end

  // Fresh press from a player not blocked since arming.
  assign candidatos = ativo & ~ativo_ant & ~mascara;

  arbitro_rr #(
    .N_JOG (N_JOG),
    .W_IDX (W_IDX)
  ) u_rr (
    .candidatos (candidatos),
    .ptr        (ptr),
    .valido     (valido),
    .vencedor   (vencedor)
  );

  // Raw button group of the current winner, captured on grant.
  always_comb begin
    botao_vencedor = '0;
    for (int p = 0; p < int'(N_JOG); p++) begin
      if (vencedor == W_IDX'(p)) begin
        botao_vencedor = bus.botoes[p*W_BOT +: W_BOT];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_nxt;
    end
  end

  // Next state plus timer, mask, pointer and result latches.
  always_comb begin
    estado_nxt  = estado;
    mascara_nxt = mascara;
    ptr_nxt     = ptr;
    timer_nxt   = timer;
    jogador_nxt = jogador_q;
    botao_nxt   = botao_q;
    jf_nxt      = jf_q;
    te_nxt      = te_q;

    if (bus.limpa) begin
      estado_nxt  = OCIOSO;
      mascara_nxt = '0;
      timer_nxt   = '0;
      jogador_nxt = '0;
      botao_nxt   = '0;
      jf_nxt      = 1'b0;
      te_nxt      = 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (bus.habilita) begin
            estado_nxt  = ARMADO;
            timer_nxt   = W_TEMPO'(TIMEOUT);
            mascara_nxt = ativo;
          end
        end
        ARMADO: begin
          // Releasing a button lifts the arming-time block for that player.
          mascara_nxt = mascara & ativo;
          if (timer != '0) begin
            timer_nxt = timer - W_TEMPO'(1);
          end
          if (valido) begin
            estado_nxt  = CONCEDIDO;
            jogador_nxt = vencedor;
            botao_nxt   = botao_vencedor;
            jf_nxt      = 1'b1;
            ptr_nxt     = (vencedor == W_IDX'(N_JOG - 1)) ? '0 : vencedor + W_IDX'(1);
          end else if (timer == '0) begin
            estado_nxt = ESGOTADO;
            te_nxt     = 1'b1;
          end
        end
        CONCEDIDO: begin
          if (bus.ack) begin
            estado_nxt  = OCIOSO;
            timer_nxt   = '0;
            jogador_nxt = '0;
            botao_nxt   = '0;
            jf_nxt      = 1'b0;
          end
        end
        ESGOTADO: begin
          if (bus.ack) begin
            estado_nxt = OCIOSO;
            timer_nxt  = '0;
            te_nxt     = 1'b0;
          end
        end
        default: begin
          estado_nxt  = OCIOSO;
          mascara_nxt = '0;
          timer_nxt   = '0;
          jogador_nxt = '0;
          botao_nxt   = '0;
          jf_nxt      = 1'b0;
          te_nxt      = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers; ativo_ant tracks button activity in every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ativo_ant <= '0;
      mascara   <= '0;
      ptr       <= '0;
      timer     <= '0;
      jogador_q <= '0;
      botao_q   <= '0;
      jf_q      <= 1'b0;
      te_q      <= 1'b0;
    end else begin
      ativo_ant <= ativo;
      mascara   <= mascara_nxt;
      ptr       <= ptr_nxt;
      timer     <= timer_nxt;
      jogador_q <= jogador_nxt;
      botao_q   <= botao_nxt;
      jf_q      <= jf_nxt;
      te_q      <= te_nxt;
    end
  end

  assign bus.jogada_feita   = jf_q;
  assign bus.jogador        = jogador_q;
  assign bus.botao_sel      = botao_q;
  assign bus.tempo_esgotado = te_q;
  assign bus.tempo_restante = timer;
  assign bus.db_estado      = W_ESTADO'(estado);

endmodule

// File: tb/tb_arbitro_jogadores.sv
// Directed bench for arbitro_jogadores with hand-computed expectations.
module tb_arbitro_jogadores;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  arbitro_jogadores_if #(.N_JOG(4), .W_BOT(4), .TIMEOUT(10)) bus ();

  arbitro_jogadores #(.N_JOG(4), .W_BOT(4), .TIMEOUT(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic saida(input string tag, input logic jf, input int unsigned jog,
                       input int unsigned bsel, input logic te, input int unsigned est);
    chk({tag, ".jogada_feita"},   32'(bus.jogada_feita),   32'(jf));
    chk({tag, ".jogador"},        32'(bus.jogador),        32'(jog));
    chk({tag, ".botao_sel"},      32'(bus.botao_sel),      32'(bsel));
    chk({tag, ".tempo_esgotado"}, 32'(bus.tempo_esgotado), 32'(te));
    chk({tag, ".db_estado"},      32'(bus.db_estado),      32'(est));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.habilita = 1'b0;
    bus.limpa    = 1'b0;
    bus.ack      = 1'b0;
    bus.botoes   = '0;
    #2;
    saida("reset", 1'b0, 0, 0, 1'b0, 0);
    chk("reset.tempo_restante", 32'(bus.tempo_restante), 32'd0);
    chk("reset.ptr", 32'(dut.ptr), 32'd0);
    #1 reset = 1'b0;

    // Player 2, button 1.
    bus.habilita = 1'b1;
    tick();
    bus.habilita = 1'b0;
    chk("arm1.db_estado", 32'(bus.db_estado), 32'd1);
    chk("arm1.tempo_restante", 32'(bus.tempo_restante), 32'd10);
    bus.botoes = 16'h0200;
    tick();
    saida("p2", 1'b1, 2, 4'b0010, 1'b0, 2);
    tick();
    saida("p2.hold", 1'b1, 2, 4'b0010, 1'b0, 2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    saida("p2.ack", 1'b0, 0, 0, 1'b0, 0);
    chk("p2.ack.tempo_restante", 32'(bus.tempo_restante), 32'd0);
    chk("p2.ptr", 32'(dut.ptr), 32'd3);
    bus.botoes = '0;
    tick();

    // Tie between players 0 and 1 with ptr = 3.
    bus.habilita = 1'b1;
    tick();
    bus.habilita = 1'b0;
    bus.botoes = 16'h0011;
    tick();
    saida("tie.ptr3", 1'b1, 0, 4'b0001, 1'b0, 2);
    chk("tie.ptr3.ptr", 32'(dut.ptr), 32'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.botoes = '0;
    tick();

    // Same tie with ptr = 1.
    bus.habilita = 1'b1;
    tick();
    bus.habilita = 1'b0;
    bus.botoes = 16'h0011;
    tick();
    saida("tie.ptr1", 1'b1, 1, 4'b0001, 1'b0, 2);
    chk("tie.ptr1.ptr", 32'(dut.ptr), 32'd2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.botoes = '0;
    tick();

    // Player 1 holds across arming; player 3 presses fresh.
    bus.botoes = 16'h0020;
    tick();
    bus.habilita = 1'b1;
    tick();
    bus.habilita = 1'b0;
    chk("mask.armed", 32'(bus.db_estado), 32'd1);
    bus.botoes = 16'h1020;
    tick();
    saida("mask.p3", 1'b1, 3, 4'b0001, 1'b0, 2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.botoes = '0;
    tick();
    bus.habilita = 1'b1;
    tick();
    bus.habilita = 1'b0;
    bus.botoes = 16'h0020;
    tick();
    saida("mask.p1", 1'b1, 1, 4'b0010, 1'b0, 2);
    chk("mask.p1.ptr", 32'(dut.ptr), 32'd2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.botoes = '0;
    tick();

    // Timeout with no press; stray habilita in ESGOTADO.
    bus.habilita = 1'b1;
    tick();
    bus.habilita = 1'b0;
    chk("to.tr10", 32'(bus.tempo_restante), 32'd10);
    for (int i = 9; i >= 0; i--) begin
      tick();
      chk("to.countdown", 32'(bus.tempo_restante), 32'(i));
      chk("to.armado", 32'(bus.db_estado), 32'd1);
      chk("to.no_flag", 32'(bus.tempo_esgotado), 32'd0);
    end
    tick();
    saida("to.esgotado", 1'b0, 0, 0, 1'b1, 3);
    bus.habilita = 1'b1;
    tick();
    bus.habilita = 1'b0;
    saida("to.hab_ignored", 1'b0, 0, 0, 1'b1, 3);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    saida("to.ack", 1'b0, 0, 0, 1'b0, 0);
    chk("to.ptr", 32'(dut.ptr), 32'd2);

    // Press on the timer = 0 cycle wins; then limpa in CONCEDIDO.
    bus.habilita = 1'b1;
    tick();
    bus.habilita = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("edge.tr0", 32'(bus.tempo_restante), 32'd0);
    bus.botoes = 16'h0001;
    tick();
    saida("edge.grant", 1'b1, 0, 4'b0001, 1'b0, 2);
    chk("edge.ptr", 32'(dut.ptr), 32'd1);
    bus.limpa = 1'b1;
    tick();
    bus.limpa = 1'b0;
    saida("limpa", 1'b0, 0, 0, 1'b0, 0);
    chk("limpa.ptr", 32'(dut.ptr), 32'd1);
    bus.botoes = '0;
    tick();

    // ack in OCIOSO / ARMADO and habilita in ARMADO are ignored.
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack.ocioso", 32'(bus.db_estado), 32'd0);
    bus.habilita = 1'b1;
    tick();
    chk("rearm.tr", 32'(bus.tempo_restante), 32'd10);
    tick();
    bus.habilita = 1'b0;
    chk("hab.armado.db", 32'(bus.db_estado), 32'd1);
    chk("hab.armado.tr", 32'(bus.tempo_restante), 32'd9);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack.armado.db", 32'(bus.db_estado), 32'd1);
    chk("ack.armado.tr", 32'(bus.tempo_restante), 32'd8);

    // Asynchronous reset mid-ARMADO.
    #2 reset = 1'b1;
    #1;
    saida("async_reset", 1'b0, 0, 0, 1'b0, 0);
    chk("async_reset.tr", 32'(bus.tempo_restante), 32'd0);
    chk("async_reset.ptr", 32'(dut.ptr), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_reset.db", 32'(bus.db_estado), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
